// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: decodes op/funct, sequences
// datapath strobes per instruction, stalls on memory, traps on bad encodings.
module mips_multicycle_ctrl #(
  parameter int OP_WIDTH       = 6,
  parameter int FUNCT_WIDTH    = 6,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OP_WIDTH-1:0]       op_i,
  input  logic [FUNCT_WIDTH-1:0]    funct_i,
  input  logic                      mem_ready_i,
  output logic                      pc_write_o,
  output logic                      pc_write_cond_o,
  output logic [1:0]                pc_src_o,
  output logic                      i_or_d_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      ir_write_o,
  output logic                      reg_dst_o,
  output logic                      mem_to_reg_o,
  output logic                      reg_write_o,
  output logic                      alu_src_a_o,
  output logic [1:0]                alu_src_b_o,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_o,
  output logic                      illegal_o,
  output logic [CNT_WIDTH-1:0]      retired_o
);

  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

  localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
  localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(4);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC, S_ALU_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  state_e                 state_q;
  logic                   is_lw_q;
  logic [CNT_WIDTH-1:0]   retired_q;
  logic                   funct_legal;
  logic                   retire;

  assign funct_legal = (funct_i == FN_ADD) || (funct_i == FN_SUB) || (funct_i == FN_AND) ||
                       (funct_i == FN_OR)  || (funct_i == FN_SLT);

  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_ADDI_WB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEM_WRITE) && mem_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_lw_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH:     if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          // Remember LW vs SW here; op_i is not guaranteed valid after DECODE.
          is_lw_q <= (op_i == OP_LW);
          if ((op_i == OP_LW) || (op_i == OP_SW)) state_q <= S_MEM_ADDR;
          else if (op_i == OP_R)                  state_q <= funct_legal ? S_EXEC : S_TRAP;
          else if (op_i == OP_BEQ)                state_q <= S_BRANCH;
          else if (op_i == OP_J)                  state_q <= S_JUMP;
          else if (op_i == OP_ADDI)               state_q <= S_ADDI_EXEC;
          else                                    state_q <= S_TRAP;
        end
        S_MEM_ADDR:  state_q <= is_lw_q ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready_i) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready_i) state_q <= S_FETCH;
        S_EXEC:      state_q <= S_ALU_WB;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_TRAP:      state_q <= S_TRAP;
        default:     state_q <= S_FETCH;
      endcase
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // Strobes decode from the registered state and are held low while rst_n is low.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'd0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_ctrl_o      = ALU_ADD;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE:    alu_src_b_o = 2'd3;
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
        end
        S_MEM_READ: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          case (funct_i)
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: alu_ctrl_o = ALU_ADD;
          endcase
        end
        S_ALU_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_ADDI_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
        end
        S_ADDI_WB:   reg_write_o = 1'b1;
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_ctrl_o      = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_src_o        = 2'd1;
        end
        S_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign illegal_o = (state_q == S_TRAP);
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle strobe vectors, stalls,
// traps, async reset and counter wrap on a 4-bit counter instance.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op_i;
  logic [5:0]  funct_i;
  logic        mem_ready_i;

  logic        pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic        reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0]  pc_src_o, alu_src_b_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] retired_o;

  logic        n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic        n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a, n_illegal;
  logic [1:0]  n_pc_src, n_alu_src_b;
  logic [3:0]  n_alu_ctrl;
  logic [3:0]  n_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct_i(funct_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  mips_multicycle_ctrl #(.CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct_i(funct_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(n_pc_write), .pc_write_cond_o(n_pc_write_cond), .pc_src_o(n_pc_src),
    .i_or_d_o(n_i_or_d), .mem_read_o(n_mem_read), .mem_write_o(n_mem_write),
    .ir_write_o(n_ir_write), .reg_dst_o(n_reg_dst), .mem_to_reg_o(n_mem_to_reg),
    .reg_write_o(n_reg_write), .alu_src_a_o(n_alu_src_a), .alu_src_b_o(n_alu_src_b),
    .alu_ctrl_o(n_alu_ctrl), .illegal_o(n_illegal), .retired_o(n_retired)
  );

  logic [17:0] ctl;
  assign ctl = {pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o,
                ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                alu_ctrl_o};

  // Field order matches ctl above.
  function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic rdst, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [3:0] alu);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, alu};
  endfunction

  logic [17:0] C_ZERO, C_FETCH_W, C_FETCH, C_DEC, C_MADDR, C_MREAD, C_MWB, C_MWRITE;
  logic [17:0] C_ALUWB, C_AEXEC, C_AWB, C_BR, C_JMP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check strobes, advance to just after the next edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [17:0] exp);
    op_i = op; funct_i = fn; mem_ready_i = rdy;
    #1;
    chk(tag, {14'd0, ctl}, {14'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic r_instr(input string nm, input logic [5:0] fn, input logic [3:0] alu);
    cyc({nm, ".fetch"}, 6'h00, fn, 1'b1, C_FETCH);
    cyc({nm, ".decode"}, 6'h00, fn, 1'b1, C_DEC);
    cyc({nm, ".exec"}, 6'h00, fn, 1'b1, mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd0,alu));
    cyc({nm, ".alu_wb"}, 6'h00, fn, 1'b1, C_ALUWB);
    $display("instr %s done retired=%0d", nm, retired_o);
  endtask

  task automatic reset_pulse(input string tag, input logic [31:0] exp_ret_before);
    chk({tag, ".ret_before"}, retired_o, exp_ret_before);
    rst_n = 1'b0;
    #1;
    chk({tag, ".ctl_in_reset"}, {14'd0, ctl}, 32'd0);
    chk({tag, ".illegal_in_reset"}, {31'd0, illegal_o}, 32'd0);
    chk({tag, ".ret_in_reset"}, retired_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset %s applied", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    C_ZERO    = 18'd0;
    C_FETCH_W = mk(0,0,2'd0,0,1,0,0,0,0,0,0,2'd1,4'd0);
    C_FETCH   = mk(1,0,2'd0,0,1,0,1,0,0,0,0,2'd1,4'd0);
    C_DEC     = mk(0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,4'd0);
    C_MADDR   = mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,4'd0);
    C_MREAD   = mk(0,0,2'd0,1,1,0,0,0,0,0,0,2'd0,4'd0);
    C_MWB     = mk(0,0,2'd0,0,0,0,0,0,1,1,0,2'd0,4'd0);
    C_MWRITE  = mk(0,0,2'd0,1,0,1,0,0,0,0,0,2'd0,4'd0);
    C_ALUWB   = mk(0,0,2'd0,0,0,0,0,1,0,1,0,2'd0,4'd0);
    C_AEXEC   = mk(0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,4'd0);
    C_AWB     = mk(0,0,2'd0,0,0,0,0,0,0,1,0,2'd0,4'd0);
    C_BR      = mk(0,1,2'd1,0,0,0,0,0,0,0,1,2'd0,4'd1);
    C_JMP     = mk(1,0,2'd2,0,0,0,0,0,0,0,0,2'd0,4'd0);

    rst_n = 1'b0; op_i = 6'h00; funct_i = 6'h00; mem_ready_i = 1'b1;
    #2;
    chk("reset.ctl", {14'd0, ctl}, 32'd0);
    chk("reset.illegal", {31'd0, illegal_o}, 32'd0);
    chk("reset.retired", retired_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R-type ADD, zero wait
    r_instr("add", 6'b100000, 4'd0);
    chk("add.retired", retired_o, 32'd1);

    // R-type SLT with one fetch stall
    cyc("slt.fetch_wait", 6'h00, 6'b101010, 1'b0, C_FETCH_W);
    r_instr("slt", 6'b101010, 4'd4);
    chk("slt.retired", retired_o, 32'd2);

    // LW with 3 stall cycles in MEM_READ
    cyc("lw.fetch", 6'b100011, 6'h00, 1'b1, C_FETCH);
    cyc("lw.decode", 6'b100011, 6'h00, 1'b1, C_DEC);
    cyc("lw.mem_addr", 6'hxx, 6'hxx, 1'b1, C_MADDR);
    for (int i = 0; i < 3; i++) cyc("lw.mem_read_stall", 6'hxx, 6'hxx, 1'b0, C_MREAD);
    cyc("lw.mem_read", 6'hxx, 6'hxx, 1'b1, C_MREAD);
    chk("lw.no_early_retire", retired_o, 32'd2);
    cyc("lw.mem_wb", 6'hxx, 6'hxx, 1'b1, C_MWB);
    chk("lw.retired", retired_o, 32'd3);
    $display("instr lw done retired=%0d", retired_o);

    // SW, BEQ, J, ADDI back-to-back
    cyc("sw.fetch", 6'b101011, 6'h00, 1'b1, C_FETCH);
    cyc("sw.decode", 6'b101011, 6'h00, 1'b1, C_DEC);
    cyc("sw.mem_addr", 6'hxx, 6'hxx, 1'b1, C_MADDR);
    cyc("sw.mem_write", 6'hxx, 6'hxx, 1'b1, C_MWRITE);
    chk("sw.retired", retired_o, 32'd4);
    cyc("beq.fetch", 6'b000100, 6'h00, 1'b1, C_FETCH);
    cyc("beq.decode", 6'b000100, 6'h00, 1'b1, C_DEC);
    cyc("beq.branch", 6'hxx, 6'hxx, 1'b1, C_BR);
    cyc("j.fetch", 6'b000010, 6'h00, 1'b1, C_FETCH);
    cyc("j.decode", 6'b000010, 6'h00, 1'b1, C_DEC);
    cyc("j.jump", 6'hxx, 6'hxx, 1'b1, C_JMP);
    cyc("addi.fetch", 6'b001000, 6'h00, 1'b1, C_FETCH);
    cyc("addi.decode", 6'b001000, 6'h00, 1'b1, C_DEC);
    cyc("addi.exec", 6'hxx, 6'hxx, 1'b1, C_AEXEC);
    cyc("addi.wb", 6'hxx, 6'hxx, 1'b1, C_AWB);
    chk("mix.retired", retired_o, 32'd7);
    $display("instr sw/beq/j/addi done retired=%0d", retired_o);

    // Illegal opcode traps and stays trapped
    cyc("trap.fetch", 6'b111111, 6'h00, 1'b1, C_FETCH);
    cyc("trap.decode", 6'b111111, 6'h00, 1'b1, C_DEC);
    for (int i = 0; i < 3; i++) begin
      chk("trap.illegal", {31'd0, illegal_o}, 32'd1);
      cyc("trap.no_strobes", 6'b100011, 6'b100000, 1'b1, C_ZERO);
    end
    chk("trap.retired_frozen", retired_o, 32'd7);
    $display("instr illegal-op trapped retired=%0d", retired_o);
    reset_pulse("trap_reset", 32'd7);
    chk("post_reset.illegal", {31'd0, illegal_o}, 32'd0);

    // Reset during a MEM_WRITE stall
    r_instr("add2", 6'b100000, 4'd0);
    cyc("swr.fetch", 6'b101011, 6'h00, 1'b1, C_FETCH);
    cyc("swr.decode", 6'b101011, 6'h00, 1'b1, C_DEC);
    cyc("swr.mem_addr", 6'hxx, 6'hxx, 1'b1, C_MADDR);
    cyc("swr.mem_write_stall", 6'hxx, 6'hxx, 1'b0, C_MWRITE);
    mem_ready_i = 1'b0;
    #1;
    chk("swr.mem_write_held", {14'd0, ctl}, {14'd0, C_MWRITE});
    reset_pulse("swr_reset", 32'd1);
    cyc("swr.restart_fetch", 6'h00, 6'b100000, 1'b1, C_FETCH);
    chk("swr.retired_after", retired_o, 32'd0);
    $display("instr sw aborted by reset retired=%0d", retired_o);

    // Unlisted R-type funct traps
    cyc("badfn.decode", 6'h00, 6'b000000, 1'b1, C_DEC);
    chk("badfn.illegal", {31'd0, illegal_o}, 32'd1);
    cyc("badfn.no_strobes", 6'h00, 6'b100000, 1'b1, C_ZERO);
    reset_pulse("badfn_reset", 32'd0);

    // 17 ADDs: 4-bit counter wraps 15 -> 0 and ends at 1
    for (int i = 1; i <= 17; i++) begin
      r_instr("wrap_add", 6'b100000, 4'd0);
      chk("wrap.wide", retired_o, i);
      chk("wrap.narrow", {28'd0, n_retired}, i % 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
